// File: rtl/debug_slave_pkg.sv
// Shared definitions for the debug-slave command path:
// entry layout helpers, default channel encodings and sequencer states.
package debug_slave_pkg;

    localparam int SR_W_DEF = 38;
    localparam int IR_W_DEF = 2;

    localparam int CH_OCIMEM    = 0;
    localparam int CH_TRACECTRL = 1;
    localparam int CH_BREAK     = 2;
    localparam int CH_TRACEMEM  = 3;

    typedef enum logic {
        ST_ARMING = 1'b0,
        ST_RUN    = 1'b1
    } seq_state_e;

    function automatic int action_bit(input int sr_w);
        return sr_w - 1;
    endfunction

    // Entry packs {chan, action, payload} with the payload in the LSBs.
    function automatic int entry_w(input int ir_w, input int sr_w);
        return ir_w + 1 + sr_w;
    endfunction

endpackage

// File: rtl/debug_slave_cmd_fifo.sv
// First-word fall-through command FIFO with wrap-bit pointers.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module debug_slave_cmd_fifo #(
    parameter int W     = 41,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_push,
    input  logic [W-1:0]             i_push_data,
    input  logic                     i_pop,
    output logic [W-1:0]             o_head,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wptr;
    logic [AW:0]  r_rptr;
    logic         w_wr;
    logic         w_rd;

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW])
                  && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_level = r_wptr - r_rptr;

    assign w_rd = i_pop && !o_empty;
    assign w_wr = i_push && (!o_full || w_rd);

    // Head is forced to zero when empty so stale entries never leak out.
    assign o_head = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_wr) begin
                r_mem[r_wptr[AW-1:0]] <= i_push_data;
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/debug_slave_cmd_sequencer.sv
// System-clock command stage: synchronises JTAG update toggles, decodes
// the virtual IR into per-channel pulses and queues each command.
module debug_slave_cmd_sequencer
    import debug_slave_pkg::*;
#(
    parameter int SR_W        = SR_W_DEF,
    parameter int IR_W        = IR_W_DEF,
    parameter int NUM_CH      = 4,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     udr_toggle,
    input  logic                     uir_toggle,
    input  logic [IR_W-1:0]          ir_in,
    input  logic [SR_W-1:0]          sr,
    output logic [NUM_CH-1:0]        take_action,
    output logic [NUM_CH-1:0]        take_no_action,
    output logic [SR_W-1:0]          jdo,
    output logic                     ir_changed,
    output logic                     cmd_valid,
    input  logic                     cmd_ready,
    output logic [IR_W-1:0]          cmd_chan,
    output logic                     cmd_action,
    output logic [SR_W-1:0]          cmd_data,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    output logic                     bad_ir,
    input  logic                     err_clr
);

    localparam int ACT = action_bit(SR_W);
    localparam int EW  = entry_w(IR_W, SR_W);
    localparam int CW  = $clog2(SYNC_STAGES + 2);
    localparam logic [IR_W:0] LP_NCH = (IR_W+1)'(NUM_CH);

    logic [SYNC_STAGES-1:0] r_udr_sync;
    logic [SYNC_STAGES-1:0] r_uir_sync;
    logic                   r_udr_prev;
    logic                   r_uir_prev;
    seq_state_e             r_state;
    seq_state_e             w_state_nxt;
    logic [CW-1:0]          r_cnt;
    logic [CW-1:0]          w_cnt_nxt;

    logic              w_udr_s;
    logic              w_uir_s;
    logic              w_udr_ev;
    logic              w_uir_ev;
    logic              w_ir_ok;
    logic [NUM_CH-1:0] w_onehot;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              w_drop;
    logic [EW-1:0]     w_entry;
    logic [EW-1:0]     w_head;

    assign w_udr_s = r_udr_sync[SYNC_STAGES-1];
    assign w_uir_s = r_uir_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_udr_sync <= '0;
            r_uir_sync <= '0;
            r_udr_prev <= 1'b0;
            r_uir_prev <= 1'b0;
        end else begin
            r_udr_sync <= {r_udr_sync[SYNC_STAGES-2:0], udr_toggle};
            r_uir_sync <= {r_uir_sync[SYNC_STAGES-2:0], uir_toggle};
            r_udr_prev <= w_udr_s;
            r_uir_prev <= w_uir_s;
        end
    end

    // Masking while arming hides the edge seen when a toggle idles high.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            ST_ARMING: begin
                if (r_cnt == CW'(SYNC_STAGES)) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_RUN: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_ARMING;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign w_udr_ev = (w_udr_s ^ r_udr_prev) && (r_state == ST_RUN);
    assign w_uir_ev = (w_uir_s ^ r_uir_prev) && (r_state == ST_RUN);

    assign w_ir_ok  = ({1'b0, ir_in} < LP_NCH);
    assign w_onehot = w_ir_ok ? (NUM_CH'(1) << ir_in) : '0;

    assign w_push  = w_udr_ev && w_ir_ok;
    assign w_pop   = cmd_valid && cmd_ready;
    assign w_drop  = w_push && w_full && !w_pop;
    assign w_entry = {ir_in, sr[ACT], sr};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            take_action    <= '0;
            take_no_action <= '0;
            ir_changed     <= 1'b0;
            jdo            <= '0;
            overflow       <= 1'b0;
            bad_ir         <= 1'b0;
        end else begin
            take_action    <= '0;
            take_no_action <= '0;
            ir_changed     <= w_uir_ev;
            if (w_udr_ev) begin
                jdo <= sr;
                if (sr[ACT]) begin
                    take_action <= w_onehot;
                end else begin
                    take_no_action <= w_onehot;
                end
            end
            overflow <= err_clr ? 1'b0 : (overflow | w_drop);
            bad_ir   <= err_clr ? 1'b0 : (bad_ir | (w_udr_ev && !w_ir_ok));
        end
    end

    debug_slave_cmd_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_push      (w_push),
        .i_push_data (w_entry),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_level     (fifo_level),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    assign cmd_valid  = !w_empty;
    assign cmd_data   = w_head[SR_W-1:0];
    assign cmd_action = w_head[SR_W];
    assign cmd_chan   = w_head[EW-1 -: IR_W];

endmodule

// File: tb/tb_debug_slave_cmd_sequencer.sv
// Directed and randomized bench for debug_slave_cmd_sequencer against a
// queue-based command model; a second NUM_CH=3 instance covers bad_ir.
module tb_debug_slave_cmd_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        udr_toggle;
    logic        uir_toggle;
    logic [1:0]  ir_in;
    logic [37:0] sr;
    logic        cmd_ready;
    logic        err_clr;
    logic        ready3;

    logic [3:0]  take_action, take_no_action;
    logic [37:0] jdo;
    logic        ir_changed, cmd_valid, cmd_action, overflow, bad_ir;
    logic [1:0]  cmd_chan;
    logic [37:0] cmd_data;
    logic [2:0]  fifo_level;

    logic [2:0]  ta3, tna3;
    logic [37:0] jdo3, data3;
    logic        irc3, valid3, act3, ovf3, bad3;
    logic [1:0]  chan3;
    logic [2:0]  level3;

    always #5 clk = ~clk;

    debug_slave_cmd_sequencer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .udr_toggle     (udr_toggle),
        .uir_toggle     (uir_toggle),
        .ir_in          (ir_in),
        .sr             (sr),
        .take_action    (take_action),
        .take_no_action (take_no_action),
        .jdo            (jdo),
        .ir_changed     (ir_changed),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_chan       (cmd_chan),
        .cmd_action     (cmd_action),
        .cmd_data       (cmd_data),
        .fifo_level     (fifo_level),
        .overflow       (overflow),
        .bad_ir         (bad_ir),
        .err_clr        (err_clr)
    );

    debug_slave_cmd_sequencer #(.NUM_CH(3)) dut3 (
        .clk            (clk),
        .reset_n        (reset_n),
        .udr_toggle     (udr_toggle),
        .uir_toggle     (uir_toggle),
        .ir_in          (ir_in),
        .sr             (sr),
        .take_action    (ta3),
        .take_no_action (tna3),
        .jdo            (jdo3),
        .ir_changed     (irc3),
        .cmd_valid      (valid3),
        .cmd_ready      (ready3),
        .cmd_chan       (chan3),
        .cmd_action     (act3),
        .cmd_data       (data3),
        .fifo_level     (level3),
        .overflow       (ovf3),
        .bad_ir         (bad3),
        .err_clr        (err_clr)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [40:0] q[$];
    int          rel;
    int          udr_due;
    int          uir_due;
    logic [3:0]  e_ta, e_tna;
    logic [2:0]  e_ta3, e_tna3;
    logic        e_irc, e_ovf, e_bad3, e_v3;
    logic [37:0] e_jdo, e_d3;

    task automatic chk(input string tag, input logic [63:0] o,
                       input logic [63:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, o, e);
        end
    endtask

    task automatic compare();
        logic [40:0] h;
        h = (q.size() > 0) ? q[0] : '0;
        chk("take_action", take_action, e_ta);
        chk("take_no_action", take_no_action, e_tna);
        chk("ir_changed", ir_changed, e_irc);
        chk("jdo", jdo, e_jdo);
        chk("cmd_valid", cmd_valid, q.size() > 0);
        chk("cmd_chan", cmd_chan, h[40:39]);
        chk("cmd_action", cmd_action, h[38]);
        chk("cmd_data", cmd_data, h[37:0]);
        chk("fifo_level", fifo_level, q.size());
        chk("overflow", overflow, e_ovf);
        chk("bad_ir", bad_ir, 1'b0);
        chk("ta3", ta3, e_ta3);
        chk("tna3", tna3, e_tna3);
        chk("irc3", irc3, e_irc);
        chk("jdo3", jdo3, e_jdo);
        chk("valid3", valid3, e_v3);
        chk("level3", level3, e_v3);
        chk("data3", data3, e_d3);
        chk("bad3", bad3, e_bad3);
        chk("ovf3", ovf3, 1'b0);
    endtask

    task automatic model_reset();
        q.delete();
        rel = 0; udr_due = 0; uir_due = 0;
        e_ta = '0; e_tna = '0; e_ta3 = '0; e_tna3 = '0;
        e_irc = 0; e_ovf = 0; e_bad3 = 0; e_v3 = 0;
        e_jdo = '0; e_d3 = '0;
    endtask

    // Synchronisers restart from 0, so a toggle idling high counts as a change.
    task automatic model_release();
        rel = 0;
        udr_due = udr_toggle ? 3 : 0;
        uir_due = uir_toggle ? 3 : 0;
    endtask

    task automatic tick();
        logic udr_ev, uir_ev, pop, push, drop, push3, badset;
        logic [3:0] oh;
        rel++;
        udr_ev = 0; uir_ev = 0;
        if (udr_due > 0) begin
            udr_due--;
            if (udr_due == 0 && rel > 3) udr_ev = 1;
        end
        if (uir_due > 0) begin
            uir_due--;
            if (uir_due == 0 && rel > 3) uir_ev = 1;
        end
        e_ta = '0; e_tna = '0; e_ta3 = '0; e_tna3 = '0;
        e_irc = uir_ev;
        pop = cmd_ready && (q.size() > 0);
        push = 0; drop = 0; push3 = 0; badset = 0;
        if (udr_ev) begin
            e_jdo = sr;
            oh = 4'b0001 << ir_in;
            if (sr[37]) e_ta = oh; else e_tna = oh;
            if (ir_in < 2'd3) begin
                push3 = 1;
                e_ta3 = e_ta[2:0];
                e_tna3 = e_tna[2:0];
            end else begin
                badset = 1;
            end
            if (q.size() == 4 && !pop) drop = 1; else push = 1;
        end
        if (pop) void'(q.pop_front());
        if (push) q.push_back({ir_in, sr[37], sr});
        e_ovf  = err_clr ? 1'b0 : (e_ovf | drop);
        e_bad3 = err_clr ? 1'b0 : (e_bad3 | badset);
        e_v3 = push3;
        e_d3 = push3 ? sr : '0;
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic flip_udr();
        udr_toggle = ~udr_toggle;
        udr_due = 3;
    endtask

    task automatic flip_uir();
        uir_toggle = ~uir_toggle;
        uir_due = 3;
    endtask

    initial begin
        reset_n = 1'b0;
        udr_toggle = 1'b1;
        uir_toggle = 1'b0;
        ir_in = 2'd0;
        sr = '0;
        cmd_ready = 1'b0;
        err_clr = 1'b0;
        ready3 = 1'b1;
        model_reset();
        #1;
        compare();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_release();
        ticks(20);

        // first command: action on channel 0
        ir_in = 2'd0;
        sr = 38'h20_0000_0001;
        flip_udr();
        ticks(6);
        cmd_ready = 1'b1;
        ticks(3);
        cmd_ready = 1'b0;

        // fill to 4 with no-action on channel 2, then overflow
        ir_in = 2'd2;
        for (int i = 0; i < 5; i++) begin
            sr = {1'b0, 37'(i + 10)};
            flip_udr();
            ticks(6);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        cmd_ready = 1'b1;
        ticks(6);
        cmd_ready = 1'b0;

        // full FIFO with a pop in the push cycle, payloads 1..5
        ir_in = 2'd1;
        for (int i = 1; i <= 4; i++) begin
            sr = 38'(i);
            flip_udr();
            ticks(6);
        end
        sr = 38'd5;
        flip_udr();
        ticks(2);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        ticks(2);
        cmd_ready = 1'b1;
        ticks(6);

        // channel 3: invalid on the NUM_CH=3 instance
        ir_in = 2'd3;
        sr = 38'h25_5555_AAAA;
        flip_udr();
        ticks(6);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // udr and uir in the same cycle
        ir_in = 2'd1;
        sr = 38'h0F_1234_5678;
        flip_udr();
        flip_uir();
        ticks(6);

        // randomized traffic
        for (int n = 0; n < 150; n++) begin
            ir_in = 2'($urandom_range(0, 3));
            sr = {6'($urandom), $urandom};
            if ($urandom_range(0, 3) != 0) flip_udr();
            if ($urandom_range(0, 2) == 0) flip_uir();
            for (int k = $urandom_range(4, 8); k > 0; k--) begin
                cmd_ready = 1'($urandom_range(0, 1));
                err_clr = ($urandom_range(0, 15) == 0);
                tick();
            end
        end
        err_clr = 1'b0;
        cmd_ready = 1'b1;
        ticks(6);

        // reset in the middle of a burst
        cmd_ready = 1'b0;
        ir_in = 2'd2;
        for (int i = 0; i < 3; i++) begin
            sr = {1'b1, 37'(i + 100)};
            flip_udr();
            ticks(5);
        end
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        compare();
        udr_toggle = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_release();
        ticks(10);
        ir_in = 2'd0;
        sr = 38'h00_0000_00C3;
        flip_udr();
        ticks(6);
        cmd_ready = 1'b1;
        ticks(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
